// File: rtl/stage_fetch_queue.sv
// stage_fetch_queue: instruction fetch stage. It issues sequential fetch
// requests under a credit limit and buffers in-order responses as {pc, insn}
// pairs in a DEPTH-entry queue that feeds decode. A jump redirects the fetch
// PC, flushes the queue and discards every response still owed to the old
// stream.
// Optional feature: define FETCH_PERF_EN to add the perf_issued and
// perf_dropped counters.
module stage_fetch_queue #(
  parameter int                ADDR_W    = 32,
  parameter int                INSN_W    = 32,
  parameter int                DEPTH     = 4,
  parameter int                PC_STEP   = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_jump,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              resp_valid,
  input  logic [INSN_W-1:0] resp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INSN_W-1:0] out_insn
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_dropped
`endif
);

  localparam int PW = $clog2(DEPTH);      // pointer width
  localparam int CW = $clog2(DEPTH + 1);  // counter width, holds 0..DEPTH
  localparam int SW = CW + 2;             // wide enough for a sum of three counters

  // Fetch address and credit bookkeeping.
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [CW-1:0]     r_live;
  logic [CW-1:0]     r_discard;

  // Output queue of {pc, insn}.
  logic [ADDR_W-1:0] r_q_pc   [DEPTH];
  logic [INSN_W-1:0] r_q_insn [DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;

  // PCs of live requests, oldest first; its occupancy always equals r_live.
  logic [ADDR_W-1:0] r_pcq [DEPTH];
  logic [PW-1:0]     r_pcq_rd;
  logic [PW-1:0]     r_pcq_wr;

  logic [SW-1:0]     w_credit_sum;
  logic              w_req_hs;
  logic              w_resp_take;
  logic              w_resp_drop;
  logic              w_resp_push;
  logic              w_out_hs;
  logic [CW-1:0]     w_discard_jump;

  // Every queue slot, live request and stale request consumes one credit, so
  // an accepted response always finds a free queue slot.
  assign w_credit_sum = SW'(r_count) + SW'(r_live) + SW'(r_discard);
  assign req_valid    = !rst && (w_credit_sum < SW'(DEPTH));
  assign req_addr     = r_fetch_pc;
  assign w_req_hs     = req_valid && req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_resp_take  = resp_valid && ((r_live != '0) || (r_discard != '0));
  // Stale responses are always older than live ones, so they are dropped first.
  assign w_resp_drop  = resp_valid && (r_discard != '0);
  assign w_resp_push  = w_resp_take && (r_discard == '0);

  assign out_valid    = (r_count != '0);
  assign out_pc       = r_q_pc[r_rd_ptr];
  assign out_insn     = r_q_insn[r_rd_ptr];
  assign w_out_hs     = out_valid && out_ready;

  // On a jump, everything in flight becomes stale, including a request
  // accepted on the jump edge, minus a response that arrives on that edge.
  assign w_discard_jump = CW'(SW'(r_discard) + SW'(r_live) + SW'(w_req_hs)
                             - SW'(w_resp_take));

  // Control state: fetch PC, pointers and counters; jump overrides all else.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others regardless of statement order.
    if (rst) begin
      r_fetch_pc <= RESET_VEC;
      r_live     <= '0;
      r_discard  <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_pcq_rd   <= '0;
      r_pcq_wr   <= '0;
    end else if (is_jump) begin
      r_fetch_pc <= jump_addr;
      r_live     <= '0;
      r_discard  <= w_discard_jump;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_pcq_rd   <= '0;
      r_pcq_wr   <= '0;
    end else begin
      if (w_req_hs) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
        r_pcq_wr   <= r_pcq_wr + PW'(1);
      end
      if (w_resp_drop) begin
        r_discard <= r_discard - CW'(1);
      end
      if (w_resp_push) begin
        r_pcq_rd <= r_pcq_rd + PW'(1);
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_out_hs) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_live  <= r_live + CW'(w_req_hs) - CW'(w_resp_push);
      r_count <= r_count + CW'(w_resp_push) - CW'(w_out_hs);
    end
  end

  // Storage writes: issued PCs into pcq, responses into the queue tail.
  always_ff @(posedge clk) begin
    // NOTE: the storage arrays have no reset; the pointers and counters decide
    // which entries are valid, so stale contents are never observed.
    if (w_req_hs) begin
      r_pcq[r_pcq_wr] <= r_fetch_pc;
    end
    if (w_resp_push) begin
      r_q_pc[r_wr_ptr]   <= r_pcq[r_pcq_rd];
      r_q_insn[r_wr_ptr] <= resp_data;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_dropped;
  logic [31:0] w_drop_inc;

  // A jump drops every queued entry plus any response arriving on that edge.
  assign w_drop_inc = is_jump ? (32'(r_count) + 32'(w_resp_take))
                              : 32'(w_resp_drop);

  // Performance counters; both wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_issued  <= '0;
      r_perf_dropped <= '0;
    end else begin
      r_perf_issued  <= r_perf_issued + 32'(w_req_hs);
      r_perf_dropped <= r_perf_dropped + w_drop_inc;
    end
  end

  assign perf_issued  = r_perf_issued;
  assign perf_dropped = r_perf_dropped;
`endif

endmodule
